// File: rtl/freq_select_divider.sv
// Programmable clock divider with glitch-free switching between table-selected divisors.
// State  | meaning
// IDLE   | no mode active, clk_out held low
// RUN    | dividing by d_act, each half-period d_act cycles
// DRAIN  | switch pending, finishing the current period through its low phase
// GUARD  | clk_out forced low for GUARD_CYCLES before the new mode starts
module freq_select_divider #(
    parameter int NUM_MODES    = 4,
    parameter int MODE_W       = 2,
    parameter int CNT_W        = 8,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_MODES*CNT_W-1:0] div_table,
    input  logic                       mode_req,
    input  logic [MODE_W-1:0]          mode_in,
    output logic                       clk_out,
    output logic [NUM_MODES-1:0]       select,
    output logic                       busy,
    output logic                       mode_ack
);

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_GUARD} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       d_act_q, d_act_d;
    logic                   clk_out_q, clk_out_d;
    logic [MODE_W-1:0]      act_q, act_d;
    logic [MODE_W-1:0]      tgt_q, tgt_d;
    logic [GW-1:0]          guard_q, guard_d;
    logic [NUM_MODES-1:0]   select_q, select_d;
    logic                   ack_q, ack_d;
    logic                   same_q, same_d;

    logic                   exit_now;
    logic [MODE_W-1:0]      exit_tgt;
    logic [CNT_W-1:0]       tgt_div;
    logic                   tgt_ok;
    logic [NUM_MODES-1:0]   tgt_sel;

    // From IDLE (zero guard) the target is the live request; otherwise the latched one.
    assign exit_tgt = (state_q == ST_IDLE) ? mode_in : tgt_q;

    always_comb begin
        tgt_div = '0;
        tgt_ok  = 1'b0;
        tgt_sel = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (exit_tgt == MODE_W'(m)) begin
                tgt_div    = div_table[m*CNT_W +: CNT_W];
                tgt_ok     = 1'b1;
                tgt_sel[m] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        d_act_d   = d_act_q;
        clk_out_d = clk_out_q;
        act_d     = act_q;
        tgt_d     = tgt_q;
        guard_d   = guard_q;
        select_d  = select_q;
        same_d    = 1'b0;
        exit_now  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mode_req) begin
                    tgt_d = mode_in;
                    if (GUARD_CYCLES == 0) begin
                        exit_now = 1'b1;
                    end else begin
                        state_d = ST_GUARD;
                        guard_d = '0;
                    end
                end
            end
            ST_RUN: begin
                if (cnt_q == d_act_q - ONE) begin
                    clk_out_d = ~clk_out_q;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
                if (mode_req) begin
                    if (mode_in == act_q) begin
                        same_d = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                        tgt_d   = mode_in;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == d_act_q - ONE) begin
                    cnt_d = '0;
                    if (clk_out_q) begin
                        clk_out_d = 1'b0;
                    end else begin
                        select_d = '0;
                        if (GUARD_CYCLES == 0) begin
                            exit_now = 1'b1;
                        end else begin
                            state_d = ST_GUARD;
                            guard_d = '0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_GUARD: begin
                if (guard_q == GUARD_LAST) begin
                    exit_now = 1'b1;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (exit_now) begin
            d_act_d = tgt_div;
            cnt_d   = '0;
            if (tgt_ok && (tgt_div != '0)) begin
                state_d   = ST_RUN;
                clk_out_d = 1'b1;
                select_d  = tgt_sel;
                act_d     = exit_tgt;
            end else begin
                state_d   = ST_IDLE;
                clk_out_d = 1'b0;
                select_d  = '0;
            end
        end

        ack_d = exit_now | same_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            d_act_q   <= '0;
            clk_out_q <= 1'b0;
            act_q     <= '0;
            tgt_q     <= '0;
            guard_q   <= '0;
            select_q  <= '0;
            ack_q     <= 1'b0;
            same_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d_act_q   <= d_act_d;
            clk_out_q <= clk_out_d;
            act_q     <= act_d;
            tgt_q     <= tgt_d;
            guard_q   <= guard_d;
            select_q  <= select_d;
            ack_q     <= ack_d;
            same_q    <= same_d;
        end
    end

    assign clk_out  = clk_out_q;
    assign select   = select_q;
    assign busy     = (state_q == ST_DRAIN) || (state_q == ST_GUARD);
    assign mode_ack = ack_q;

endmodule

// File: tb/tb_freq_select_divider.sv
// Bench for freq_select_divider: directed table, corner sequences and random traffic vs a period-arithmetic model.
module tb_freq_select_divider;

    localparam int NM = 4;
    localparam int MW = 2;
    localparam int CW = 8;
    localparam int G  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NM*CW-1:0]  div_table;
    logic              mode_req = 1'b0;
    logic [MW-1:0]     mode_in = '0;
    logic              clk_out;
    logic [NM-1:0]     select;
    logic              busy;
    logic              mode_ack;

    freq_select_divider #(.NUM_MODES(NM), .MODE_W(MW), .CNT_W(CW), .GUARD_CYCLES(G)) dut (
        .clk(clk), .reset(reset), .div_table(div_table), .mode_req(mode_req),
        .mode_in(mode_in), .clk_out(clk_out), .select(select), .busy(busy), .mode_ack(mode_ack)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: ph 0=idle, 1=running, 2=switching. Waveform derived from start cycle and divisor.
    int m_ph, m_s, m_D, m_mode, m_E, m_X, m_tgt;
    bit ack_set[int];

    typedef struct {
        bit         req;
        logic [1:0] mode;
        bit         c;
        logic [3:0] sel;
        bit         b;
        bit         a;
    } vec_t;
    vec_t vecs[20];

    function automatic vec_t mk(bit req, logic [1:0] mode, bit c, logic [3:0] sel, bit b, bit a);
        vec_t v;
        v.req = req; v.mode = mode; v.c = c; v.sel = sel; v.b = b; v.a = a;
        return v;
    endfunction

    function automatic int dtab(input int m);
        return int'(div_table[m*CW +: CW]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_s = 0; m_D = 1; m_mode = 0; m_E = 0; m_X = 0; m_tgt = 0;
        ack_set.delete();
    endtask

    task automatic model_step(input bit req, input int mi);
        int n;
        int dn;
        n = cyc;
        if (m_ph == 2 && n == m_X) begin
            dn = dtab(m_tgt);
            if (dn != 0) begin
                m_ph = 1; m_s = n; m_D = dn; m_mode = m_tgt;
            end else begin
                m_ph = 0;
            end
            ack_set[n] = 1'b1;
        end else if (req && m_ph != 2) begin
            if (m_ph == 0) begin
                m_ph = 2; m_E = n; m_X = n + G; m_tgt = mi;
            end else if (mi == m_mode) begin
                ack_set[n+1] = 1'b1;
            end else begin
                m_ph = 2;
                m_E  = m_s + 2*m_D*((n - m_s)/(2*m_D) + 1);
                m_X  = m_E + G;
                m_tgt = mi;
            end
        end
    endtask

    task automatic check_model(input string name);
        bit c, b, a;
        logic [3:0] sel;
        int n;
        n = cyc; c = 1'b0; b = 1'b0; sel = '0;
        if (m_ph == 1 || (m_ph == 2 && n < m_E)) begin
            c = (((n - m_s) / m_D) % 2) == 0;
            sel[m_mode] = 1'b1;
        end
        b = (m_ph == 2);
        a = ack_set.exists(n);
        chk({name, "_clk"}, 32'(clk_out), 32'(c));
        chk({name, "_sel"}, 32'(select), 32'(sel));
        chk({name, "_busy"}, 32'(busy), 32'(b));
        chk({name, "_ack"}, 32'(mode_ack), 32'(a));
    endtask

    task automatic tick(input bit req, input int mi);
        mode_req = req;
        mode_in  = MW'(mi);
        @(posedge clk);
        cyc++;
        model_step(req, mi);
        @(negedge clk);
        mode_req = 1'b0;
    endtask

    task automatic wait_sel(input logic [3:0] s, input string name);
        for (int k = 0; k < 60 && select !== s; k++) begin
            tick(1'b0, 0);
            check_model(name);
        end
        chk({name, "_reached"}, 32'(select), 32'(s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        div_table = {8'd5, 8'd0, 8'd3, 8'd1};
        model_reset();

        vecs[0]  = mk(1, 2'd1, 0, 4'b0000, 1, 0);
        vecs[1]  = mk(0, 2'd0, 0, 4'b0000, 1, 0);
        vecs[2]  = mk(0, 2'd0, 1, 4'b0010, 0, 1);
        vecs[3]  = mk(0, 2'd0, 1, 4'b0010, 0, 0);
        vecs[4]  = mk(0, 2'd0, 1, 4'b0010, 0, 0);
        vecs[5]  = mk(0, 2'd0, 0, 4'b0010, 0, 0);
        vecs[6]  = mk(0, 2'd0, 0, 4'b0010, 0, 0);
        vecs[7]  = mk(0, 2'd0, 0, 4'b0010, 0, 0);
        vecs[8]  = mk(0, 2'd0, 1, 4'b0010, 0, 0);
        vecs[9]  = mk(0, 2'd0, 1, 4'b0010, 0, 0);
        vecs[10] = mk(1, 2'd0, 1, 4'b0010, 1, 0);
        vecs[11] = mk(0, 2'd0, 0, 4'b0010, 1, 0);
        vecs[12] = mk(0, 2'd0, 0, 4'b0010, 1, 0);
        vecs[13] = mk(0, 2'd0, 0, 4'b0010, 1, 0);
        vecs[14] = mk(0, 2'd0, 0, 4'b0000, 1, 0);
        vecs[15] = mk(0, 2'd0, 0, 4'b0000, 1, 0);
        vecs[16] = mk(0, 2'd0, 1, 4'b0001, 0, 1);
        vecs[17] = mk(0, 2'd0, 0, 4'b0001, 0, 0);
        vecs[18] = mk(0, 2'd0, 1, 4'b0001, 0, 0);
        vecs[19] = mk(0, 2'd0, 0, 4'b0001, 0, 0);

        repeat (3) @(negedge clk);
        chk("rst_clk", 32'(clk_out), 32'(0));
        chk("rst_sel", 32'(select), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ack", 32'(mode_ack), 32'(0));
        reset = 1'b1;

        for (int i = 0; i < 50; i++) begin
            tick(1'b0, 0);
            check_model("idle");
        end

        for (int i = 0; i < 20; i++) begin
            tick(vecs[i].req, int'(vecs[i].mode));
            chk($sformatf("vec%0d_clk", i), 32'(clk_out), 32'(vecs[i].c));
            chk($sformatf("vec%0d_sel", i), 32'(select), 32'(vecs[i].sel));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].b));
            chk($sformatf("vec%0d_ack", i), 32'(mode_ack), 32'(vecs[i].a));
            check_model("vec_model");
        end

        // Ignored second request while switching
        tick(1'b1, 3);
        check_model("t4_go3");
        wait_sel(4'b1000, "t4_run3");
        tick(1'b0, 0); check_model("t4_pre");
        acks = 0;
        tick(1'b1, 1); check_model("t4_req1"); acks += int'(mode_ack);
        tick(1'b0, 0); check_model("t4_gap");  acks += int'(mode_ack);
        tick(1'b1, 0); check_model("t4_req0"); acks += int'(mode_ack);
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 0);
            check_model("t4_run");
            acks += int'(mode_ack);
        end
        chk("t4_acks", 32'(acks), 32'(1));
        chk("t4_sel", 32'(select), 32'(4'b0010));

        // Same-mode request: ack one cycle after acceptance, waveform untouched
        tick(1'b1, 1);
        check_model("t4_same");
        chk("t4_same_ackT", 32'(mode_ack), 32'(0));
        tick(1'b0, 0);
        check_model("t4_same1");
        chk("t4_same_ackT1", 32'(mode_ack), 32'(1));
        chk("t4_same_busy", 32'(busy), 32'(0));
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 0);
            check_model("t4_after");
        end

        // Switch to an off mode
        tick(1'b1, 3);
        check_model("t5_go3");
        wait_sel(4'b1000, "t5_run3");
        tick(1'b0, 0); check_model("t5_pre");
        acks = 0;
        tick(1'b1, 2); check_model("t5_req2"); acks += int'(mode_ack);
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 0);
            check_model("t5_run");
            acks += int'(mode_ack);
        end
        chk("t5_acks", 32'(acks), 32'(1));
        chk("t5_sel", 32'(select), 32'(0));
        chk("t5_clk", 32'(clk_out), 32'(0));
        chk("t5_busy", 32'(busy), 32'(0));

        // Asynchronous reset mid-high-phase
        tick(1'b1, 3);
        check_model("t6_go3");
        wait_sel(4'b1000, "t6_run3");
        tick(1'b0, 0); check_model("t6_h2");
        tick(1'b0, 0); check_model("t6_h3");
        chk("t6_high", 32'(clk_out), 32'(1));
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_clk", 32'(clk_out), 32'(0));
        chk("t6_rst_sel", 32'(select), 32'(0));
        chk("t6_rst_busy", 32'(busy), 32'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 0);
            check_model("t6_idle");
        end

        // Random traffic with occasional divisor table rewrites
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) begin
                for (int m = 0; m < NM; m++)
                    div_table[m*CW +: CW] = CW'($urandom_range(0, 4));
            end
            tick(($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
